// File: rtl/ltl_nfa_engine.sv
// -----------------------------------------------------------------------------
// ltl_nfa_engine
//
// Runtime-programmable homogeneous NFA monitor. NUM_STE state-transition
// elements (STEs) each hold a symbol-class bitmap (2^SYM_W bits), a successor
// row, and start/report attributes. One SYM_W-bit trace symbol is consumed per
// sym_valid/sym_ready handshake. STEs that become active with report_en set
// push a {symbol index, reporting vector} entry into a first-word fall-through
// report FIFO.
//
// Ports
//   clk, reset        clock; synchronous active-high reset (clears config too)
//   run               stream enable; a 0->1 edge starts a new sequence
//   cfg_we            config write strobe, honoured only while run=0
//   cfg_sel           0 = class word, 1 = successor row, 2 = attributes,
//                     3 = reserved
//   cfg_ste           target STE index
//   cfg_word          class word index (32 class bits per word)
//   cfg_data          write data
//   sym_valid/ready   symbol handshake; sym is the trace symbol
//   rpt_valid/ready   report FIFO head handshake
//   rpt_index         symbol index of the head entry (0 when empty)
//   rpt_vec           reporting STEs of the head entry (0 when empty)
//   active            current active-state vector
//   rpt_count         total reports pushed, saturating at 0xFFFF
// -----------------------------------------------------------------------------
module ltl_nfa_engine #(
  parameter int NUM_STE   = 16,
  parameter int SYM_W     = 8,
  parameter int RPT_DEPTH = 8,
  parameter int CNT_W     = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       run,
  input  logic                       cfg_we,
  input  logic [1:0]                 cfg_sel,
  input  logic [$clog2(NUM_STE)-1:0] cfg_ste,
  input  logic [2:0]                 cfg_word,
  input  logic [31:0]                cfg_data,
  input  logic                       sym_valid,
  output logic                       sym_ready,
  input  logic [SYM_W-1:0]           sym,
  output logic                       rpt_valid,
  input  logic                       rpt_ready,
  output logic [CNT_W-1:0]           rpt_index,
  output logic [NUM_STE-1:0]         rpt_vec,
  output logic [NUM_STE-1:0]         active,
  output logic [15:0]                rpt_count
);

  localparam int STE_W     = $clog2(NUM_STE);
  localparam int CLS_BITS  = 1 << SYM_W;
  localparam int CLS_WORDS = CLS_BITS / 32;
  localparam int AW        = $clog2(RPT_DEPTH);
  localparam logic [AW:0] FIFO_FULL = (AW+1)'(RPT_DEPTH);

  // ---------------------------------------------------------------------------
  // Engine state
  // ---------------------------------------------------------------------------
  logic               r_run_d;
  logic               r_sod;
  logic [NUM_STE-1:0] r_active;
  logic [CNT_W-1:0]   r_index;
  logic [15:0]        r_rpt_count;

  // FIFO storage and pointers
  logic [CNT_W-1:0]   r_fifo_idx [RPT_DEPTH];
  logic [NUM_STE-1:0] r_fifo_vec [RPT_DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [AW:0]        r_fifo_cnt;

  // ---------------------------------------------------------------------------
  // Per-STE configuration, exported as flat vectors
  // ---------------------------------------------------------------------------
  logic               w_cfg_en;
  logic [NUM_STE-1:0] w_cls_hit;
  logic [NUM_STE-1:0] w_start_sod;
  logic [NUM_STE-1:0] w_start_all;
  logic [NUM_STE-1:0] w_rpt_en;
  logic [NUM_STE-1:0] w_succ_row [NUM_STE];

  // Config is frozen while a stream is running so the automaton the trace is
  // evaluated against cannot change under it.
  assign w_cfg_en = cfg_we & ~run;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STE; gi++) begin : g_ste
      logic [CLS_BITS-1:0] r_class;
      logic [NUM_STE-1:0]  r_succ;
      logic                r_sod_en;
      logic                r_all_en;
      logic                r_rep_en;
      logic                w_sel;

      // Indices >= NUM_STE match no STE and are dropped.
      assign w_sel = w_cfg_en && (cfg_ste == STE_W'(gi));

      always_ff @(posedge clk) begin
        if (reset) begin
          r_class  <= '0;
          r_succ   <= '0;
          r_sod_en <= 1'b0;
          r_all_en <= 1'b0;
          r_rep_en <= 1'b0;
        end else if (w_sel) begin
          case (cfg_sel)
            2'd0: begin
              // Word indices beyond the bitmap never match and are dropped.
              for (int w = 0; w < CLS_WORDS; w++) begin
                if (cfg_word == 3'(w)) begin
                  r_class[w*32 +: 32] <= cfg_data;
                end
              end
            end
            2'd1: r_succ <= cfg_data[NUM_STE-1:0];
            2'd2: begin
              r_sod_en <= cfg_data[0];
              r_all_en <= cfg_data[1];
              r_rep_en <= cfg_data[2];
            end
            default: ;
          endcase
        end
      end

      assign w_cls_hit[gi]   = r_class[sym];
      assign w_start_sod[gi] = r_sod_en;
      assign w_start_all[gi] = r_all_en;
      assign w_rpt_en[gi]    = r_rep_en;
      assign w_succ_row[gi]  = r_succ;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Transition function
  // ---------------------------------------------------------------------------
  logic [NUM_STE-1:0] w_pred;
  logic [NUM_STE-1:0] w_enable;
  logic [NUM_STE-1:0] w_next;
  logic [NUM_STE-1:0] w_rpt;

  // Union of the successor rows of every currently active STE.
  always_comb begin
    w_pred = '0;
    for (int i = 0; i < NUM_STE; i++) begin
      if (r_active[i]) begin
        w_pred = w_pred | w_succ_row[i];
      end
    end
  end

  assign w_enable = w_start_all | (w_start_sod & {NUM_STE{r_sod}}) | w_pred;
  assign w_next   = w_enable & w_cls_hit;
  assign w_rpt    = w_next & w_rpt_en;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic w_start;
  logic w_full;
  logic w_accept;
  logic w_push;
  logic w_pop;

  assign w_start   = run & ~r_run_d;
  assign w_full    = (r_fifo_cnt == FIFO_FULL);
  // Stalling on a full FIFO even for non-reporting symbols keeps the ready
  // path independent of the (deep) class/successor lookup.
  assign sym_ready = run & ~w_start & ~w_full;
  assign w_accept  = sym_valid & sym_ready;
  assign w_push    = w_accept & (|w_rpt);
  assign w_pop     = rpt_valid & rpt_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_run_d  <= 1'b0;
      r_sod    <= 1'b0;
      r_active <= '0;
      r_index  <= '0;
    end else begin
      r_run_d <= run;
      if (w_start) begin
        r_active <= '0;
        r_index  <= '0;
        r_sod    <= 1'b1;
      end else if (w_accept) begin
        r_active <= w_next;
        r_index  <= r_index + CNT_W'(1);
        r_sod    <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Report FIFO (first-word fall-through)
  // ---------------------------------------------------------------------------
  // Storage is never reset; the empty state is carried by the pointers and
  // the head outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_idx[r_wr_ptr] <= r_index;
      r_fifo_vec[r_wr_ptr] <= w_rpt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + (AW+1)'(1);
        2'b01:   r_fifo_cnt <= r_fifo_cnt - (AW+1)'(1);
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rpt_count <= '0;
    end else if (w_push && (r_rpt_count != 16'hFFFF)) begin
      r_rpt_count <= r_rpt_count + 16'd1;
    end
  end

  assign rpt_valid = (r_fifo_cnt != '0);
  assign rpt_index = rpt_valid ? r_fifo_idx[r_rd_ptr] : '0;
  assign rpt_vec   = rpt_valid ? r_fifo_vec[r_rd_ptr] : '0;
  assign active    = r_active;
  assign rpt_count = r_rpt_count;

endmodule

// File: tb/tb_ltl_nfa_engine.sv
// -----------------------------------------------------------------------------
// tb_ltl_nfa_engine
//
// Directed scenarios plus a randomized phase. A behavioural model of the
// automaton (per-symbol class tables, successor lists, a report queue) is
// stepped every cycle and every DUT output is compared against it on the
// falling edge. Directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_ltl_nfa_engine;

  localparam int N  = 16;
  localparam int SW = 8;
  localparam int D  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          run;
  logic          cfg_we;
  logic [1:0]    cfg_sel;
  logic [3:0]    cfg_ste;
  logic [2:0]    cfg_word;
  logic [31:0]   cfg_data;
  logic          sym_valid;
  logic          sym_ready;
  logic [SW-1:0] sym;
  logic          rpt_valid;
  logic          rpt_ready;
  logic [CW-1:0] rpt_index;
  logic [N-1:0]  rpt_vec;
  logic [N-1:0]  active;
  logic [15:0]   rpt_count;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ltl_nfa_engine #(
    .NUM_STE  (N),
    .SYM_W    (SW),
    .RPT_DEPTH(D),
    .CNT_W    (CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .cfg_we   (cfg_we),
    .cfg_sel  (cfg_sel),
    .cfg_ste  (cfg_ste),
    .cfg_word (cfg_word),
    .cfg_data (cfg_data),
    .sym_valid(sym_valid),
    .sym_ready(sym_ready),
    .sym      (sym),
    .rpt_valid(rpt_valid),
    .rpt_ready(rpt_ready),
    .rpt_index(rpt_index),
    .rpt_vec  (rpt_vec),
    .active   (active),
    .rpt_count(rpt_count)
  );

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  typedef struct {
    int          idx;
    logic [15:0] vec;
  } rpt_t;

  bit          m_class [N][256];
  logic [15:0] m_succ  [N];
  bit          m_st_sod [N];
  bit          m_st_all [N];
  bit          m_rep    [N];
  logic [15:0] m_active;
  int          m_index;
  int          m_count;
  bit          m_sod;
  bit          m_run_prev;
  bit          m_live = 1'b0;
  rpt_t        m_q[$];

  function automatic void model_clear();
    for (int s = 0; s < N; s++) begin
      for (int b = 0; b < 256; b++) m_class[s][b] = 1'b0;
      m_succ[s]   = '0;
      m_st_sod[s] = 1'b0;
      m_st_all[s] = 1'b0;
      m_rep[s]    = 1'b0;
    end
    m_active   = '0;
    m_index    = 0;
    m_count    = 0;
    m_sod      = 1'b0;
    m_run_prev = 1'b0;
    m_q.delete();
  endfunction

  // Advance the model by one clock edge using the inputs that edge samples.
  function automatic void model_step();
    bit          start;
    bit          ready;
    bit          pop;
    bit          push;
    logic [15:0] nx;
    logic [15:0] rep;
    rpt_t        e;
    if (reset) begin
      model_clear();
      m_live = 1'b1;
      return;
    end
    if (!m_live) return;
    start = run && !m_run_prev;
    ready = run && m_run_prev && (m_q.size() < D);
    pop   = (m_q.size() != 0) && rpt_ready;
    push  = 1'b0;
    if (cfg_we && !run) begin
      case (cfg_sel)
        2'd0: for (int b = 0; b < 32; b++) m_class[cfg_ste][cfg_word*32 + b] = cfg_data[b];
        2'd1: m_succ[cfg_ste] = cfg_data[15:0];
        2'd2: begin
          m_st_sod[cfg_ste] = cfg_data[0];
          m_st_all[cfg_ste] = cfg_data[1];
          m_rep[cfg_ste]    = cfg_data[2];
        end
        default: ;
      endcase
    end
    if (start) begin
      m_active = '0;
      m_index  = 0;
      m_sod    = 1'b1;
    end else if (sym_valid && ready) begin
      nx  = '0;
      rep = '0;
      for (int j = 0; j < N; j++) begin
        bit en;
        en = m_st_all[j] || (m_st_sod[j] && m_sod);
        for (int i = 0; i < N; i++) begin
          if (m_active[i] && m_succ[i][j]) en = 1'b1;
        end
        nx[j]  = en && m_class[j][sym];
        rep[j] = nx[j] && m_rep[j];
      end
      if (rep != 0) begin
        push  = 1'b1;
        e.idx = m_index;
        e.vec = rep;
      end
      m_active = nx;
      m_sod    = 1'b0;
      m_index  = (m_index + 1) % (1 << CW);
    end
    if (pop) void'(m_q.pop_front());
    if (push) begin
      m_q.push_back(e);
      if (m_count < 16'hFFFF) m_count++;
    end
    m_run_prev = run;
  endfunction

  // Compare process: outputs are sampled on the falling edge, then the model
  // is advanced for the next rising edge.
  always @(negedge clk) begin : cmp
    logic          exp_ready;
    logic          exp_valid;
    logic [CW-1:0] exp_idx;
    logic [15:0]   exp_vec;
    if (m_live) begin
      exp_valid = (m_q.size() != 0);
      exp_idx   = exp_valid ? CW'(m_q[0].idx) : '0;
      exp_vec   = exp_valid ? m_q[0].vec : 16'd0;
      exp_ready = run && m_run_prev && (m_q.size() < D);
      n_chk++;
      if (sym_ready !== exp_ready || rpt_valid !== exp_valid || rpt_index !== exp_idx ||
          rpt_vec !== exp_vec || active !== m_active || rpt_count !== 16'(m_count)) begin
        n_err++;
        $display("FAIL outputs t=%0t ready got %b exp %b | valid got %b exp %b | index got %0d exp %0d | vec got %h exp %h | active got %h exp %h | count got %0d exp %0d",
                 $time, sym_ready, exp_ready, rpt_valid, exp_valid, rpt_index, exp_idx,
                 rpt_vec, exp_vec, active, m_active, rpt_count, m_count);
      end
    end
    model_step();
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  task automatic cfg_wr(input int sel, input int ste, input int word, input logic [31:0] data);
    cfg_we   = 1'b1;
    cfg_sel  = 2'(sel);
    cfg_ste  = 4'(ste);
    cfg_word = 3'(word);
    cfg_data = data;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    run       = 1'b0;
    sym_valid = 1'b0;
    rpt_ready = 1'b0;
    cfg_we    = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic run_start();
    run = 1'b1;
    tick();
  endtask

  task automatic send(input logic [7:0] s);
    int budget;
    budget    = 0;
    sym       = s;
    sym_valid = 1'b1;
    while (!sym_ready && budget < 50) begin
      tick();
      budget++;
    end
    n_chk++;
    if (!sym_ready) begin
      n_err++;
      $display("FAIL send_timeout sym=0x%02h ready got 0 required 1", s);
      sym_valid = 1'b0;
      return;
    end
    tick();
    sym_valid = 1'b0;
    $display("sym 0x%02h accepted", s);
  endtask

  task automatic prog_all_class(input int ste);
    for (int w = 0; w < 8; w++) cfg_wr(0, ste, w, 32'hFFFF_FFFF);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int acc;
    int pops[$];
    reset = 1'b1; run = 1'b0; cfg_we = 1'b0; cfg_sel = '0; cfg_ste = '0;
    cfg_word = '0; cfg_data = '0; sym_valid = 1'b0; sym = '0; rpt_ready = 1'b0;

    // Reset state
    do_reset();
    chk("reset_ready", 32'(sym_ready), 0);
    chk("reset_valid", 32'(rpt_valid), 0);
    chk("reset_index", 32'(rpt_index), 0);
    chk("reset_vec",   32'(rpt_vec), 0);
    chk("reset_active", 32'(active), 0);
    chk("reset_count", 32'(rpt_count), 0);

    // Single STE, start-of-data only
    cfg_wr(0, 0, 0, 32'h0000_FFFF);
    cfg_wr(2, 0, 0, 32'h5);
    cfg_wr(1, 0, 0, 32'h0);
    run_start();
    send(8'h05);
    chk("t1_valid", 32'(rpt_valid), 1);
    chk("t1_index", 32'(rpt_index), 0);
    chk("t1_vec",   32'(rpt_vec), 32'h1);
    chk("t1_model_q", 32'(m_q.size()), 1);
    send(8'h05);
    chk("t1_active", 32'(active), 0);
    chk("t1_count", 32'(rpt_count), 1);
    rpt_ready = 1'b1;
    tick();
    chk("t1_drained", 32'(rpt_valid), 0);

    // Two-STE chain
    do_reset();
    cfg_wr(0, 0, 0, 32'hFFFF_0000);
    cfg_wr(2, 0, 0, 32'h2);
    cfg_wr(1, 0, 0, 32'h0002);
    cfg_wr(0, 1, 2, 32'hFFFF_FFFF);
    cfg_wr(0, 1, 3, 32'hFFFF_FFFF);
    cfg_wr(2, 1, 0, 32'h4);
    run_start();
    send(8'h12);
    chk("t2_active0", 32'(active), 32'h1);
    send(8'h45);
    send(8'h45);
    chk("t2_count", 32'(rpt_count), 1);
    chk("t2_index", 32'(rpt_index), 1);
    chk("t2_vec",   32'(rpt_vec), 32'h2);
    chk("t2_active", 32'(active), 0);

    // Self-loop, FIFO back-pressure
    do_reset();
    prog_all_class(2);
    cfg_wr(2, 2, 0, 32'h5);
    cfg_wr(1, 2, 0, 32'h0004);
    run_start();
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      sym_valid = 1'b1;
      sym = 8'($urandom);
      if (sym_ready) acc++;
      tick();
    end
    chk("t3_stall_after", 32'(acc), 8);
    chk("t3_ready_low", 32'(sym_ready), 0);
    rpt_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      sym_valid = (acc < 10);
      sym = 8'($urandom);
      if (sym_valid && sym_ready) acc++;
      if (rpt_valid && rpt_ready) begin
        pops.push_back(int'(rpt_index));
        $display("report popped index %0d vec %h", rpt_index, rpt_vec);
      end
      tick();
    end
    sym_valid = 1'b0;
    chk("t3_pop_count", 32'(pops.size()), 10);
    for (int i = 0; i < pops.size() && i < 10; i++) chk("t3_pop_order", 32'(pops[i]), 32'(i));

    // Mid-stream run drop and reconfiguration
    do_reset();
    cfg_wr(0, 0, 0, 32'h0000_FFFF);
    cfg_wr(2, 0, 0, 32'h5);
    cfg_wr(1, 0, 0, 32'h0001);
    rpt_ready = 1'b1;
    run_start();
    send(8'h05);
    chk("t4_idx0", 32'(rpt_index), 0);
    send(8'h06);
    chk("t4_idx1", 32'(rpt_index), 1);
    cfg_wr(0, 0, 0, 32'h0);
    cfg_wr(2, 0, 0, 32'h0);
    send(8'h07);
    chk("t4_cfg_locked_idx", 32'(rpt_index), 2);
    chk("t4_cfg_locked_vec", 32'(rpt_vec), 32'h1);
    run = 1'b0;
    tick();
    chk("t4_hold_active", 32'(active), 32'h1);
    chk("t4_ready_off", 32'(sym_ready), 0);
    chk("t4_count", 32'(rpt_count), 3);
    cfg_wr(0, 0, 0, 32'h0000_0F00);
    run_start();
    chk("t4_restart_active", 32'(active), 0);
    send(8'h09);
    chk("t4_restart_idx", 32'(rpt_index), 0);
    chk("t4_restart_vec", 32'(rpt_vec), 32'h1);
    send(8'h05);
    chk("t4_new_class_miss", 32'(active), 0);
    chk("t4_count2", 32'(rpt_count), 4);

    // Reset with pending reports
    do_reset();
    prog_all_class(2);
    cfg_wr(2, 2, 0, 32'h5);
    cfg_wr(1, 2, 0, 32'h0004);
    run_start();
    send(8'h01);
    send(8'h02);
    send(8'h03);
    chk("t5_pending", 32'(rpt_count), 3);
    reset = 1'b1;
    tick();
    chk("t5_valid", 32'(rpt_valid), 0);
    chk("t5_active", 32'(active), 0);
    chk("t5_count", 32'(rpt_count), 0);
    reset = 1'b0;
    run = 1'b0;
    tick();
    run_start();
    send(8'h33);
    tick();
    chk("t5_no_report", 32'(rpt_valid), 0);
    chk("t5_count_after", 32'(rpt_count), 0);

    // Randomized phase
    do_reset();
    for (int s = 0; s < N; s++) begin
      for (int w = 0; w < 8; w++) cfg_wr(0, s, w, $urandom);
      cfg_wr(1, s, 0, $urandom & $urandom & $urandom);
      cfg_wr(2, s, 0, $urandom);
    end
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 39) == 0) run = ~run;
      cfg_we    = ($urandom_range(0, 9) == 0);
      cfg_sel   = 2'($urandom);
      cfg_ste   = 4'($urandom);
      cfg_word  = 3'($urandom);
      cfg_data  = $urandom & $urandom;
      sym_valid = 1'($urandom);
      sym       = 8'($urandom);
      rpt_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    reset = 1'b0; cfg_we = 1'b0; sym_valid = 1'b0;
    $display("random phase: 3000 cycles applied");

    // Index wrap and report-count saturation
    do_reset();
    prog_all_class(2);
    cfg_wr(2, 2, 0, 32'h5);
    cfg_wr(1, 2, 0, 32'h0004);
    rpt_ready = 1'b1;
    run_start();
    pops.delete();
    for (int n = 0; n < 65545; n++) begin
      sym_valid = 1'b1;
      sym = 8'($urandom);
      if (rpt_valid && rpt_ready && pops.size() < 20) pops.push_back(int'(rpt_index));
      tick();
    end
    sym_valid = 1'b0;
    chk("t6_pop_seen", 32'(pops.size()), 20);
    if (pops.size() >= 17) begin
      chk("t6_index15", 32'(pops[15]), 15);
      chk("t6_index_wrap", 32'(pops[16]), 0);
    end
    chk("t6_saturated", 32'(rpt_count), 32'hFFFF);
    $display("saturation phase: 65545 symbols streamed");
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
